// File: rtl/ddr_burst_reader_pkg.sv
// Shared types and sizing helpers for the DDR burst read engine.
package ddr_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int burst_bytes(input int words, input int width);
        return (words * width) / 8;
    endfunction

    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

    localparam int DEF_BURST_WORDS = 64;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int BURST_BYTES     = burst_bytes(DEF_BURST_WORDS, DEF_DATA_WIDTH);

endpackage

// File: rtl/ddr_burst_reader_pending.sv
// One-deep holding register for burst requests that arrive while the engine is occupied.
module ddr_req_pending #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  idle,
    input  logic                  clear_err,
    output logic                  pend_valid,
    output logic [ADDR_WIDTH-1:0] pend_addr,
    output logic                  overrun_err
);

    logic                  valid_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  ovr_r;
    logic                  pop_s;
    logic                  store_s;
    logic                  drop_s;

    // A go only bypasses this register when the engine is idle with nothing queued.
    always_comb begin
        pop_s   = idle & valid_r;
        store_s = go & ~(idle & ~valid_r);
        drop_s  = store_s & valid_r & ~pop_s;
    end

    // Holding register plus sticky overrun flag; a drop outranks clear_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            addr_r  <= '0;
            ovr_r   <= 1'b0;
        end else begin
            if (store_s && !drop_s) begin
                valid_r <= 1'b1;
                addr_r  <= addr;
            end else if (pop_s) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                ovr_r <= 1'b1;
            end else if (clear_err) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign pend_valid  = valid_r;
    assign pend_addr   = addr_r;
    assign overrun_err = ovr_r;

endmodule

// File: rtl/ddr_burst_reader.sv
// IPIF master read engine: one fixed-length DDR burst per go, words streamed into the pixel FIFO.
// Optional single reissue of an errored burst when DDR_BURST_RETRY_EN is defined.
module ddr_burst_reader
    import ddr_burst_reader_pkg::*;
#(
    parameter int BURST_WORDS = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Resetn,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  clear_err,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun_err,
    output logic                  bus_err,
    output logic                  IP2Bus_MstRd_Req,
    output logic [ADDR_WIDTH-1:0] IP2Bus_Mst_Addr,
    output logic [11:0]           IP2Bus_Mst_Length,
    input  logic                  Bus2IP_Mst_CmdAck,
    input  logic                  Bus2IP_Mst_Cmplt,
    input  logic                  Bus2IP_Mst_Error,
    input  logic [DATA_WIDTH-1:0] Bus2IP_MstRd_d,
    input  logic                  Bus2IP_MstRd_src_rdy_n,
    output logic                  IP2Bus_MstRd_dst_rdy_n,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full
);

    localparam int                    CNT_W      = cnt_width(BURST_WORDS);
    localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(BURST_WORDS);
    localparam logic [11:0]           BURST_LEN  = 12'(burst_bytes(BURST_WORDS, DATA_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(DATA_WIDTH / 8 - 1));

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] go_addr_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  cmplt_seen_r;
    logic                  bus_err_r;
    logic                  beat_s;
    logic                  err_end_s;
    logic                  ok_end_s;
    logic                  retry_s;
    logic                  bus_err_set_s;
    logic                  pend_valid_s;
    logic [ADDR_WIDTH-1:0] pend_addr_s;

    assign go_addr_s = start_addr & ALIGN_MASK;

    ddr_req_pending #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pending (
        .clk        (Bus2IP_Clk),
        .rst_n      (Bus2IP_Resetn),
        .go         (go),
        .addr       (go_addr_s),
        .idle       (state_r == ST_IDLE),
        .clear_err  (clear_err),
        .pend_valid (pend_valid_s),
        .pend_addr  (pend_addr_s),
        .overrun_err(overrun_err)
    );

`ifdef DDR_BURST_RETRY_EN
    logic retry_r;

    // Marks that the one permitted reissue of the current request has been used.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            retry_r <= 1'b0;
        end else if (state_r == ST_XFER && retry_s) begin
            retry_r <= 1'b1;
        end else if (state_r == ST_DONE) begin
            retry_r <= 1'b0;
        end
    end

    assign retry_s = err_end_s & ~retry_r;
`else
    assign retry_s = 1'b0;
`endif

    // Beat acceptance and burst-termination decode.
    always_comb begin
        beat_s        = (state_r == ST_XFER) & ~Bus2IP_MstRd_src_rdy_n & ~fifo_full;
        cnt_nxt_s     = cnt_r + {{(CNT_W-1){1'b0}}, beat_s};
        err_end_s     = (state_r == ST_XFER) & Bus2IP_Mst_Cmplt & Bus2IP_Mst_Error;
        ok_end_s      = (state_r == ST_XFER) & (cnt_nxt_s == LAST_CNT)
                        & (cmplt_seen_r | Bus2IP_Mst_Cmplt) & ~err_end_s;
        bus_err_set_s = err_end_s & ~retry_s;
    end

    // Next-state logic; a queued request always outranks a fresh go.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pend_valid_s || go) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (Bus2IP_Mst_CmdAck) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_XFER: begin
                if (retry_s) begin
                    state_nxt_s = ST_REQ;
                end else if (err_end_s || ok_end_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, command address, beat counter and completion/error flags.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            cnt_r        <= '0;
            cmplt_seen_r <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_IDLE && pend_valid_s) begin
                addr_r <= pend_addr_s;
            end else if (state_r == ST_IDLE && go) begin
                addr_r <= go_addr_s;
            end
            if (state_r == ST_XFER) begin
                cnt_r <= cnt_nxt_s;
                if (Bus2IP_Mst_Cmplt) begin
                    cmplt_seen_r <= 1'b1;
                end
            end else begin
                cnt_r        <= '0;
                cmplt_seen_r <= 1'b0;
            end
            if (bus_err_set_s) begin
                bus_err_r <= 1'b1;
            end else if (clear_err) begin
                bus_err_r <= 1'b0;
            end
        end
    end

    assign IP2Bus_MstRd_Req       = (state_r == ST_REQ);
    assign IP2Bus_Mst_Addr        = addr_r;
    assign IP2Bus_Mst_Length      = BURST_LEN;
    assign IP2Bus_MstRd_dst_rdy_n = (state_r == ST_XFER) ? fifo_full : 1'b1;
    assign fifo_wr_en             = beat_s;
    assign fifo_wr_data           = Bus2IP_MstRd_d;
    assign done                   = (state_r == ST_DONE);
    assign busy                   = (state_r != ST_IDLE) | pend_valid_s;
    assign bus_err                = bus_err_r;

endmodule

// File: tb/tb_ddr_burst_reader.sv
// Self-checking bench for ddr_burst_reader: table vectors, corner sequences and randomized bursts.
module tb_ddr_burst_reader;

    localparam int BW       = 64;
    localparam int CM_AFTER = 0;
    localparam int CM_WITH  = 1;
    localparam int CM_EARLY = 2;

    logic        Bus2IP_Clk = 1'b0;
    logic        Bus2IP_Resetn = 1'b0;
    logic        go = 1'b0;
    logic [31:0] start_addr = 32'h0;
    logic        clear_err = 1'b0;
    logic        busy, done, overrun_err, bus_err;
    logic        IP2Bus_MstRd_Req;
    logic [31:0] IP2Bus_Mst_Addr;
    logic [11:0] IP2Bus_Mst_Length;
    logic        Bus2IP_Mst_CmdAck = 1'b0;
    logic        Bus2IP_Mst_Cmplt = 1'b0;
    logic        Bus2IP_Mst_Error = 1'b0;
    logic [31:0] Bus2IP_MstRd_d = 32'h0;
    logic        Bus2IP_MstRd_src_rdy_n = 1'b1;
    logic        IP2Bus_MstRd_dst_rdy_n;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_full = 1'b0;

    ddr_burst_reader dut (
        .Bus2IP_Clk            (Bus2IP_Clk),
        .Bus2IP_Resetn         (Bus2IP_Resetn),
        .go                    (go),
        .start_addr            (start_addr),
        .clear_err             (clear_err),
        .busy                  (busy),
        .done                  (done),
        .overrun_err           (overrun_err),
        .bus_err               (bus_err),
        .IP2Bus_MstRd_Req      (IP2Bus_MstRd_Req),
        .IP2Bus_Mst_Addr       (IP2Bus_Mst_Addr),
        .IP2Bus_Mst_Length     (IP2Bus_Mst_Length),
        .Bus2IP_Mst_CmdAck     (Bus2IP_Mst_CmdAck),
        .Bus2IP_Mst_Cmplt      (Bus2IP_Mst_Cmplt),
        .Bus2IP_Mst_Error      (Bus2IP_Mst_Error),
        .Bus2IP_MstRd_d        (Bus2IP_MstRd_d),
        .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
        .IP2Bus_MstRd_dst_rdy_n(IP2Bus_MstRd_dst_rdy_n),
        .fifo_wr_en            (fifo_wr_en),
        .fifo_wr_data          (fifo_wr_data),
        .fifo_full             (fifo_full)
    );

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_issue_q[$];
    int          m_out = 0;
    bit          m_overrun = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          ack_dly;
        int          st_lo;
        int          st_hi;
        int          err_beats;
        int          cmode;
        logic [31:0] exp_addr;
        int          exp_writes;
        logic        exp_bus_err;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO-side monitor: collect written words, forbid writes while full, count done pulses.
    always @(negedge Bus2IP_Clk) begin
        if (fifo_wr_en === 1'b1) begin
            got_q.push_back(fifo_wr_data);
            n_checks++;
            if (fifo_full !== 1'b0) begin
                n_errors++;
                $display("FAIL write_while_full: got fifo_full=%b expected 0", fifo_full);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    // Request acceptance rule: at most one active plus one queued, anything more is dropped.
    function automatic void model_go(input logic [31:0] a);
        if (m_out < 2) begin
            exp_issue_q.push_back(a & 32'hFFFF_FFFC);
            m_out++;
        end else begin
            m_overrun = 1'b1;
        end
    endfunction

    task automatic cyc();
        @(posedge Bus2IP_Clk);
        #1;
    endtask

    task automatic issue_go(input logic [31:0] a);
        go = 1'b1;
        start_addr = a;
        model_go(a);
        cyc();
        go = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        check(name, 64'({busy, done, overrun_err, bus_err, IP2Bus_MstRd_Req, fifo_wr_en,
                         IP2Bus_MstRd_dst_rdy_n}), 64'b0000001);
        check({name, "_addr"}, 64'(IP2Bus_Mst_Addr), 64'h0);
    endtask

    task automatic run_burst(input logic [31:0] exp_addr, input int ack_dly, input int st_lo,
                             input int st_hi, input int err_beats, input int cmode, input bit gaps,
                             input int inj_beat, input int inj_cnt, input logic [31:0] inj_addr,
                             output int n_wr);
        int          n_att;
        int          d0;
        int          t;
        int          nb;
        int          errs;
        bit          with_err;
        logic [31:0] w;
        n_att = 1;
        d0    = done_cnt;
`ifdef DDR_BURST_RETRY_EN
        if (err_beats > 0) n_att = 2;
`endif
        for (int att = 0; att < n_att; att++) begin
            t = 0;
            while (IP2Bus_MstRd_Req !== 1'b1 && t < 50) begin
                cyc();
                t++;
            end
            check("req_seen", 64'(t < 50), 64'd1);
            check("req_addr", 64'(IP2Bus_Mst_Addr), 64'(exp_addr));
            check("req_len", 64'(IP2Bus_Mst_Length), 64'd256);
            Bus2IP_MstRd_src_rdy_n = 1'b0;
            Bus2IP_MstRd_d = 32'hDEAD_BEEF;
            for (int k = 0; k < ack_dly; k++) begin
                #2;
                check("dst_rdy_n_in_req", 64'(IP2Bus_MstRd_dst_rdy_n), 64'd1);
                cyc();
                check("req_hold", 64'(IP2Bus_MstRd_Req), 64'd1);
            end
            Bus2IP_MstRd_src_rdy_n = 1'b1;
            Bus2IP_Mst_CmdAck = 1'b1;
            cyc();
            Bus2IP_Mst_CmdAck = 1'b0;
            check("req_drop", 64'(IP2Bus_MstRd_Req), 64'd0);
            with_err = (err_beats > 0) && (att == 0);
            nb = with_err ? err_beats : BW;
            for (int i = 0; i < nb; i++) begin
                w = $urandom;
                if (gaps && $urandom_range(0, 5) == 0) cyc();
                if (i >= inj_beat && i < inj_beat + inj_cnt) begin
                    go = 1'b1;
                    start_addr = inj_addr + 32'(i - inj_beat) * 32'h100;
                    model_go(start_addr);
                end
                Bus2IP_MstRd_src_rdy_n = 1'b0;
                Bus2IP_MstRd_d = w;
                if (i >= st_lo && i < st_hi) begin
                    fifo_full = 1'b1;
                    #2;
                    check("stall_dst_rdy_n", 64'(IP2Bus_MstRd_dst_rdy_n), 64'd1);
                    check("stall_no_write", 64'(fifo_wr_en), 64'd0);
                    cyc();
                    go = 1'b0;
                    fifo_full = 1'b0;
                end
                if (!with_err && ((cmode == CM_WITH && i == nb - 1) ||
                                  (cmode == CM_EARLY && i == nb - 8))) begin
                    Bus2IP_Mst_Cmplt = 1'b1;
                end
                exp_q.push_back(w);
                cyc();
                go = 1'b0;
                Bus2IP_Mst_Cmplt = 1'b0;
                Bus2IP_MstRd_src_rdy_n = 1'b1;
            end
            if (with_err) begin
                Bus2IP_Mst_Cmplt = 1'b1;
                Bus2IP_Mst_Error = 1'b1;
                cyc();
                Bus2IP_Mst_Cmplt = 1'b0;
                Bus2IP_Mst_Error = 1'b0;
            end else if (cmode == CM_AFTER) begin
                Bus2IP_Mst_Cmplt = 1'b1;
                cyc();
                Bus2IP_Mst_Cmplt = 1'b0;
            end
            if (att < n_att - 1) begin
                check("retry_req", 64'(IP2Bus_MstRd_Req), 64'd1);
                check("retry_no_done", 64'(done), 64'd0);
            end else begin
                check("done_pulse", 64'(done), 64'd1);
            end
        end
        cyc();
        check("done_one_cycle", 64'(done), 64'd0);
        if (m_out > 0) m_out--;
        check("done_count", 64'(done_cnt - d0), 64'd1);
        n_wr = got_q.size();
        check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
        errs = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) errs++;
        end
        check("write_data", 64'(errs), 64'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          n_wr;
        int          t;
        int          d0;
        int          lo;

        vecs[0] = '{32'h0010_0003, 3, 0, 0, 0, CM_AFTER, 32'h0010_0000, 64, 1'b0};
        vecs[1] = '{32'h0000_1004, 0, 10, 20, 0, CM_WITH, 32'h0000_1004, 64, 1'b0};
        vecs[2] = '{32'h0000_2002, 1, 0, 0, 0, CM_EARLY, 32'h0000_2000, 64, 1'b0};
`ifdef DDR_BURST_RETRY_EN
        vecs[3] = '{32'h0000_3000, 2, 0, 0, 20, CM_AFTER, 32'h0000_3000, 84, 1'b0};
`else
        vecs[3] = '{32'h0000_3000, 2, 0, 0, 20, CM_AFTER, 32'h0000_3000, 20, 1'b1};
`endif

        repeat (3) cyc();
        #2;
        check_reset_vals("reset_state");
        Bus2IP_Resetn = 1'b1;
        cyc();

        for (int v = 0; v < 4; v++) begin
            issue_go(vecs[v].addr);
            a = exp_issue_q.pop_front();
            run_burst(vecs[v].exp_addr, vecs[v].ack_dly, vecs[v].st_lo, vecs[v].st_hi,
                      vecs[v].err_beats, vecs[v].cmode, 1'b0, -1, 0, 32'h0, n_wr);
            check("vec_writes", 64'(n_wr), 64'(vecs[v].exp_writes));
            check("vec_bus_err", 64'(bus_err), 64'(vecs[v].exp_bus_err));
            check("vec_busy_after", 64'(busy), 64'd0);
            clear_err = 1'b1;
            cyc();
            clear_err = 1'b0;
            check("vec_bus_err_cleared", 64'(bus_err), 64'd0);
        end

        // Two extra requests during one burst: first queued, second dropped.
        issue_go(32'h0000_0100);
        a = exp_issue_q.pop_front();
        run_burst(32'h0000_0100, 1, 0, 0, 0, CM_AFTER, 1'b0, 5, 2, 32'h0000_0200, n_wr);
        check("ovr_set", 64'(overrun_err), 64'd1);
        check("ovr_busy_pending", 64'(busy), 64'd1);
        a = exp_issue_q.pop_front();
        run_burst(32'h0000_0200, 0, 0, 0, 0, CM_WITH, 1'b0, -1, 0, 32'h0, n_wr);
        repeat (4) cyc();
        check("ovr_no_third_req", 64'(IP2Bus_MstRd_Req), 64'd0);
        check("ovr_idle", 64'(busy), 64'd0);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        check("ovr_cleared", 64'(overrun_err), 64'd0);

        // Asynchronous reset after 30 beats of a burst.
        issue_go(32'h0000_5000);
        a = exp_issue_q.pop_front();
        t = 0;
        while (IP2Bus_MstRd_Req !== 1'b1 && t < 50) begin
            cyc();
            t++;
        end
        check("rst_req_seen", 64'(t < 50), 64'd1);
        Bus2IP_Mst_CmdAck = 1'b1;
        cyc();
        Bus2IP_Mst_CmdAck = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 30; i++) begin
            Bus2IP_MstRd_src_rdy_n = 1'b0;
            Bus2IP_MstRd_d = $urandom;
            exp_q.push_back(Bus2IP_MstRd_d);
            cyc();
        end
        Bus2IP_Resetn = 1'b0;
        #2;
        check_reset_vals("rst_async");
        cyc();
        check_reset_vals("rst_edge");
        Bus2IP_MstRd_src_rdy_n = 1'b1;
        cyc();
        Bus2IP_Resetn = 1'b1;
        cyc();
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_partial_writes", 64'(got_q.size()), 64'd30);
        got_q.delete();
        exp_q.delete();
        exp_issue_q.delete();
        m_out = 0;
        issue_go(32'h0000_6000);
        a = exp_issue_q.pop_front();
        run_burst(32'h0000_6000, 2, 0, 0, 0, CM_WITH, 1'b0, -1, 0, 32'h0, n_wr);
        check("rst_fresh_writes", 64'(n_wr), 64'd64);

        // New go on the cycle the engine returns to idle with a request already queued.
        issue_go(32'h0000_7000);
        a = exp_issue_q.pop_front();
        run_burst(32'h0000_7000, 0, 0, 0, 0, CM_AFTER, 1'b0, 3, 1, 32'h0000_8000, n_wr);
        issue_go(32'h0000_9000);
        a = exp_issue_q.pop_front();
        run_burst(32'h0000_8000, 1, 0, 0, 0, CM_AFTER, 1'b0, -1, 0, 32'h0, n_wr);
        a = exp_issue_q.pop_front();
        run_burst(32'h0000_9000, 1, 0, 0, 0, CM_AFTER, 1'b0, -1, 0, 32'h0, n_wr);
        check("order_idle", 64'(busy), 64'd0);
        check("order_no_overrun", 64'(overrun_err), 64'd0);

        // Randomized bursts with stalls, gaps and extra requests, checked against the model.
        m_overrun = 1'b0;
        for (int r = 0; r < 6; r++) begin
            if (exp_issue_q.size() == 0) issue_go($urandom);
            a = exp_issue_q.pop_front();
            lo = int'($urandom_range(0, 50));
            run_burst(a, int'($urandom_range(0, 4)), lo, lo + int'($urandom_range(0, 12)), 0,
                      int'($urandom_range(0, 2)), 1'b1, int'($urandom_range(0, 60)),
                      int'($urandom_range(0, 2)), $urandom, n_wr);
            check("rand_writes", 64'(n_wr), 64'd64);
        end
        for (int g = 0; g < 3 && exp_issue_q.size() > 0; g++) begin
            a = exp_issue_q.pop_front();
            run_burst(a, 1, 0, 0, 0, CM_AFTER, 1'b1, -1, 0, 32'h0, n_wr);
        end
        check("rand_idle", 64'(busy), 64'd0);
        check("rand_overrun", 64'(overrun_err), 64'(m_overrun));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr_burst_reader.md
Name: ddr_burst_reader

Overview:
- Read-side bus-master engine directly downstream of the line-fetch FSM.
- Each one-cycle `go` pulse, with its DDR byte address, becomes one fixed-length burst read of BURST_WORDS words over the IPIF master read interface.
- Returned words are pushed into the pixel FIFO that feeds the HDMI core.
- One request can be held pending while a burst is in flight, so back-to-back half-line and line-end requests are never lost.

Parameters:
- BURST_WORDS, 64: words per burst; power of two, 2..256.
- DATA_WIDTH, 32: bus and FIFO word width in bits; byte length = BURST_WORDS*DATA_WIDTH/8.
- ADDR_WIDTH, 32: DDR byte address width.

Ports:
- Bus2IP_Clk  in  1  single clock.
- Bus2IP_Resetn  in  1  reset; asynchronous assert, active-low.
- go  in  1  one-cycle burst request strobe.
- start_addr  in  ADDR_WIDTH  burst byte address, sampled when go=1.
- clear_err  in  1  clears sticky flags.
- busy  out  1  burst in flight or request pending.
- done  out  1  one-cycle pulse at burst end.
- overrun_err  out  1  sticky: a request was dropped.
- bus_err  out  1  sticky: a burst completed with error.
- IP2Bus_MstRd_Req  out  1  read command request.
- IP2Bus_Mst_Addr  out  ADDR_WIDTH  command address.
- IP2Bus_Mst_Length  out  12  command byte length.
- Bus2IP_Mst_CmdAck  in  1  command accepted.
- Bus2IP_Mst_Cmplt  in  1  transfer complete pulse.
- Bus2IP_Mst_Error  in  1  error, valid with Cmplt.
- Bus2IP_MstRd_d  in  DATA_WIDTH  read data.
- Bus2IP_MstRd_src_rdy_n  in  1  data valid, active-low.
- IP2Bus_MstRd_dst_rdy_n  out  1  ready for data, active-low.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_WIDTH  FIFO write word.
- fifo_full  in  1  FIFO full.

Behaviour:
- Reset values while Bus2IP_Resetn=0:
  - State IDLE, pending register empty.
  - All counters 0; busy, done, overrun_err, bus_err, IP2Bus_MstRd_Req, fifo_wr_en = 0.
  - IP2Bus_MstRd_dst_rdy_n = 1; IP2Bus_Mst_Addr = 0.
- Address handling: low log2(DATA_WIDTH/8) bits are forced to 0.
- Pending register (1 deep):
  - go while IDLE with pending empty: captured as the active request.
  - go at any other time: stored in pending if empty; otherwise dropped and overrun_err set.
- States:
  - IDLE: on go or non-empty pending, go to REQ. Pending has priority over a simultaneous go; that go is then stored in pending.
  - REQ: IP2Bus_MstRd_Req=1, Addr and Length held stable. Stay until CmdAck=1, then go to XFER. Req drops the cycle after CmdAck.
  - XFER:
    - IP2Bus_MstRd_dst_rdy_n = fifo_full.
    - Beat accepted when src_rdy_n=0 and dst_rdy_n=0. Each accepted beat: fifo_wr_en=1 and fifo_wr_data=Bus2IP_MstRd_d in the same cycle (combinational); word count increments.
    - Capture Cmplt/Error into flags (Cmplt may arrive before or with the last beat).
    - Go to DONE when word count = BURST_WORDS and Cmplt is seen, or on any Cmplt with Error=1 (bus_err set, remaining beats abandoned).
  - DONE: done=1 for one cycle, counters clear, then IDLE.
- busy = (state != IDLE) or pending non-empty.
- fifo_full only stalls data; it never drops words. The FIFO is never written while full.
- Beats arriving outside XFER are ignored; dst_rdy_n=1 outside XFER.
- clear_err clears both sticky flags. If it coincides with a setting event, the set wins.
- An async reset mid-burst abandons the burst immediately; no done pulse is issued.

Optional Feature:
- Macro: DDR_BURST_RETRY_EN.
- Defined: a burst ending with Error=1 is reissued once from REQ with the same address.
  - The FIFO is not rewound; words already written stay.
  - bus_err sets only if the retry also errors.
  - done pulses once, after the final attempt.
  - A 1-bit retry counter is added.
- Undefined: no retry. The first error sets bus_err and ends the burst.

Decomposition:
- Shared package (e.g. hdmi_out_pkg) holds:
  - state encoding constants ST_IDLE, ST_REQ, ST_XFER, ST_DONE;
  - BURST_BYTES derived constant;
  - word-count width function clog2(BURST_WORDS+1).
- Natural sub-module: ddr_req_pending, the 1-deep request holding register with overrun detection. It is instantiated once.

Test Plan:
1. go with start_addr=0x0010_0003, CmdAck after 3 cycles, 64 beats with no stalls -> Addr=0x0010_0000, Length=256, 64 fifo_wr_en pulses, data in order, done one cycle after the last beat/Cmplt, busy=0 afterwards.
2. fifo_full=1 for beats 10-19 of 64 -> dst_rdy_n=1 during those cycles, no write while full, exactly 64 writes in total, no data lost or duplicated.
3. Second go (0x200) during burst 1, third go (0x300) also during burst 1 -> burst 2 at 0x200 starts after done, overrun_err=1, no burst at 0x300; clear_err then clears the flag.
4. Cmplt with Error=1 after 20 beats -> bus_err=1, done pulses, exactly 20 writes. With DDR_BURST_RETRY_EN: second Req to the same address, bus_err stays 0 if the retry succeeds.
5. Bus2IP_Resetn low mid-XFER after 30 beats -> all outputs at reset values on the next edge, no done pulse; a fresh go after release runs a normal 64-beat burst.
6. go in the same cycle the FSM returns to IDLE with a request pending -> pending address issued first, new go queued, two bursts in that order.
